// File: rtl/cnn_dispatch_pkg.sv
// rtl/cnn_dispatch_pkg.sv - shared constants for the CNN job dispatcher
//
// Contents:
//   DEF_DATA_W, DEF_IMG_WORDS     default word width and words per frame
//   ERR_SHORT/ERR_LONG/ERR_TIMEOUT bit positions in the sticky err vector
//   state_t, ST_*                  dispatcher FSM state encoding
//   idx_w()                        index width helper, never below 1 bit
package cnn_dispatch_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_IMG_WORDS = 64;

   localparam int ERR_SHORT   = 0;
   localparam int ERR_LONG    = 1;
   localparam int ERR_TIMEOUT = 2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOAD     = 3'd1;
   localparam state_t ST_DRAIN    = 3'd2;
   localparam state_t ST_CORE_RST = 3'd3;
   localparam state_t ST_LAUNCH   = 3'd4;
   localparam state_t ST_WAIT     = 3'd5;
   localparam state_t ST_RESULT   = 3'd6;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/img_frame_buffer.sv
// rtl/img_frame_buffer.sv - IMG_WORDS x DATA_W frame register file
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all words)
//   wr_en, wr_idx       write strobe and word index
//   wr_data             word to store
//   img_flat            flattened read-out, word i at [i*DATA_W +: DATA_W]
module img_frame_buffer #(
   parameter int DATA_W    = 32,
   parameter int IMG_WORDS = 64,
   parameter int IDX_W     = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [IDX_W-1:0]            wr_idx,
   input  logic [DATA_W-1:0]           wr_data,
   output logic [IMG_WORDS*DATA_W-1:0] img_flat
);

   logic [DATA_W-1:0] mem [IMG_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IMG_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      img_flat = '0;
      for (int i = 0; i < IMG_WORDS; i++) begin
         img_flat[i*DATA_W +: DATA_W] = mem[i];
      end
   end

endmodule

// File: rtl/cnn_job_dispatcher.sv
// rtl/cnn_job_dispatcher.sv - buffers one image, runs a CNN core job, returns its result
//
// Optional feature macro: CNN_DISPATCH_PERF_EN adds perf_cycles (LAUNCH-to-done
// cycle count of the last successful job, saturating).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   image word input stream
//   core_rst, core_enable      one-cycle core reset and launch pulses
//   core_img                   flattened frame buffer to the core
//   core_done, core_value      core completion pulse and result
//   m_valid/m_data/m_ready     result output stream
//   busy                       high outside IDLE
//   err, err_clr               sticky error flags and their clear
//   perf_cycles                (macro only) job duration in cycles
module cnn_job_dispatcher
   import cnn_dispatch_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int IMG_WORDS      = DEF_IMG_WORDS,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_last,
   output logic                        s_ready,
   output logic                        core_rst,
   output logic                        core_enable,
   output logic [IMG_WORDS*DATA_W-1:0] core_img,
   input  logic                        core_done,
   input  logic [DATA_W-1:0]           core_value,
   output logic                        m_valid,
   output logic [DATA_W-1:0]           m_data,
   input  logic                        m_ready,
   output logic                        busy,
   output logic [2:0]                  err,
   input  logic                        err_clr
`ifdef CNN_DISPATCH_PERF_EN
   ,
   output logic [31:0]                 perf_cycles
`endif
);

   localparam int CW = idx_w(IMG_WORDS);
   localparam int TW = idx_w(TIMEOUT_CYCLES);

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tmo_cnt;
   logic [2:0]    err_set;

   logic          accept;
   logic          loading;
   logic          wr_en;
   logic [CW-1:0] wr_idx;
   logic          last_idx;
   logic          tmo_hit;

   assign accept   = s_valid & s_ready;
   assign loading  = (state == ST_IDLE) || (state == ST_LOAD);
   // IDLE always writes word 0, so cnt need not be valid there.
   assign wr_idx   = (state == ST_IDLE) ? '0 : cnt;
   assign wr_en    = accept & loading;
   assign last_idx = (wr_idx == CW'(IMG_WORDS - 1));
   assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_n = state;
      err_set = '0;
      case (state)
         ST_IDLE, ST_LOAD: begin
            if (accept) begin
               if (s_last && !last_idx) begin
                  err_set[ERR_SHORT] = 1'b1;
                  state_n            = ST_IDLE;
               end else if (last_idx) begin
                  err_set[ERR_LONG] = !s_last;
                  state_n           = s_last ? ST_CORE_RST : ST_DRAIN;
               end else begin
                  state_n = ST_LOAD;
               end
            end
         end
         ST_DRAIN: begin
            if (accept && s_last) state_n = ST_CORE_RST;
         end
         ST_CORE_RST: state_n = ST_LAUNCH;
         ST_LAUNCH:   state_n = ST_WAIT;
         ST_WAIT: begin
            // done takes priority over a timeout in the same cycle
            if (core_done) begin
               state_n = ST_RESULT;
            end else if (tmo_hit) begin
               err_set[ERR_TIMEOUT] = 1'b1;
               state_n              = ST_IDLE;
            end
         end
         ST_RESULT: begin
            if (m_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // s_ready is registered from the next state so it stays low during reset
   // and during the first cycle after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         tmo_cnt <= '0;
         s_ready <= 1'b0;
         m_data  <= '0;
         err     <= '0;
      end else begin
         state   <= state_n;
         s_ready <= (state_n == ST_IDLE) || (state_n == ST_LOAD) || (state_n == ST_DRAIN);
         if (wr_en) begin
            cnt <= (state_n == ST_LOAD) ? wr_idx + 1'b1 : '0;
         end
         if (state == ST_LAUNCH) begin
            tmo_cnt <= '0;
         end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (state == ST_WAIT && core_done) begin
            m_data <= core_value;
         end
         err <= (err & ~{3{err_clr}}) | err_set;
      end
   end

   assign core_rst    = (state == ST_CORE_RST);
   assign core_enable = (state == ST_LAUNCH);
   assign m_valid     = (state == ST_RESULT);
   assign busy        = (state != ST_IDLE);

`ifdef CNN_DISPATCH_PERF_EN
   // perf_run counts cycles since LAUNCH; it reads 1 in the first WAIT cycle.
   logic [31:0] perf_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_run    <= '0;
         perf_cycles <= '0;
      end else begin
         if (state == ST_LAUNCH) begin
            perf_run <= 32'd1;
         end else if (state == ST_WAIT && perf_run != '1) begin
            perf_run <= perf_run + 32'd1;
         end
         if (state == ST_WAIT && core_done) begin
            perf_cycles <= perf_run;
         end
      end
   end
`endif

   img_frame_buffer #(
      .DATA_W   (DATA_W),
      .IMG_WORDS(IMG_WORDS),
      .IDX_W    (CW)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (s_data),
      .img_flat(core_img)
   );

endmodule

// File: tb/tb_cnn_job_dispatcher.sv
// tb/tb_cnn_job_dispatcher.sv - scoreboard bench for cnn_job_dispatcher
//
// Two instances: u_a (TIMEOUT_CYCLES=4096) for normal jobs, u_b (TIMEOUT_CYCLES=16)
// for timeout cases; sel routes the shared stimulus and core model to one of them.
module tb_cnn_job_dispatcher;

   localparam int DW = 32;
   localparam int NW = 64;

   logic clk = 1'b0;
   logic rst, s_valid, s_last, m_ready, err_clr, core_done, sel;
   logic [DW-1:0] s_data, core_value;

   logic a_s_ready, a_core_rst, a_core_enable, a_m_valid, a_busy;
   logic b_s_ready, b_core_rst, b_core_enable, b_m_valid, b_busy;
   logic [NW*DW-1:0] a_img, b_img, cur_img;
   logic [DW-1:0] a_m_data, b_m_data, cur_m_data;
   logic [2:0] a_err, b_err, cur_err;
   logic cur_s_ready, cur_core_rst, cur_core_enable, cur_m_valid, cur_busy;
`ifdef CNN_DISPATCH_PERF_EN
   logic [31:0] a_perf, b_perf;
`endif

   always #5 clk = ~clk;

   cnn_job_dispatcher #(.DATA_W(DW), .IMG_WORDS(NW), .TIMEOUT_CYCLES(4096)) u_a (
      .clk(clk), .rst(rst),
      .s_valid(s_valid & ~sel), .s_data(s_data), .s_last(s_last), .s_ready(a_s_ready),
      .core_rst(a_core_rst), .core_enable(a_core_enable), .core_img(a_img),
      .core_done(core_done & ~sel), .core_value(core_value),
      .m_valid(a_m_valid), .m_data(a_m_data), .m_ready(m_ready & ~sel),
      .busy(a_busy), .err(a_err), .err_clr(err_clr)
`ifdef CNN_DISPATCH_PERF_EN
      , .perf_cycles(a_perf)
`endif
   );

   cnn_job_dispatcher #(.DATA_W(DW), .IMG_WORDS(NW), .TIMEOUT_CYCLES(16)) u_b (
      .clk(clk), .rst(rst),
      .s_valid(s_valid & sel), .s_data(s_data), .s_last(s_last), .s_ready(b_s_ready),
      .core_rst(b_core_rst), .core_enable(b_core_enable), .core_img(b_img),
      .core_done(core_done & sel), .core_value(core_value),
      .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(m_ready & sel),
      .busy(b_busy), .err(b_err), .err_clr(err_clr)
`ifdef CNN_DISPATCH_PERF_EN
      , .perf_cycles(b_perf)
`endif
   );

   assign cur_s_ready     = sel ? b_s_ready     : a_s_ready;
   assign cur_core_rst    = sel ? b_core_rst    : a_core_rst;
   assign cur_core_enable = sel ? b_core_enable : a_core_enable;
   assign cur_img         = sel ? b_img         : a_img;
   assign cur_m_valid     = sel ? b_m_valid     : a_m_valid;
   assign cur_m_data      = sel ? b_m_data      : a_m_data;
   assign cur_busy        = sel ? b_busy        : a_busy;
   assign cur_err         = sel ? b_err         : a_err;

   int n_chk = 0;
   int n_pass = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every result handshake is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (!rst && cur_m_valid && m_ready) begin
         if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
         else check("result_data", cur_m_data, exp_q.pop_front());
      end
   end

   // Core model: pulses done core_dly cycles after an enable (0 = never).
   int core_dly = 20;
   int en_cnt = 0;
   logic [DW-1:0] core_val = '0;
   initial begin
      logic [DW-1:0] v;
      core_done = 1'b0;
      core_value = '0;
      forever begin
         @(posedge clk); #1;
         if (cur_core_enable) begin
            en_cnt++;
            if (core_dly > 0) begin
               v = core_val;
               repeat (core_dly) @(posedge clk);
               #1;
               core_done = 1'b1;
               core_value = v;
               @(posedge clk); #1;
               core_done = 1'b0;
               core_value = '0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Words base+1 .. base+n, s_last on word n.
   task automatic send_frame(input int n, input int base, input bit lat_chk);
      int tries;
      for (int i = 1; i <= n; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(base + i);
         s_last  = (i == n);
         tries = 0;
         while (!cur_s_ready && tries < 50) begin
            step();
            tries++;
         end
         if (tries >= 50) begin
            check("s_ready_wait", 64'd0, 64'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (lat_chk) begin
         check("core_rst_T+1", cur_core_rst, 1);
         check("core_en_T+1", cur_core_enable, 0);
         step();
         check("core_rst_T+2", cur_core_rst, 0);
         check("core_en_T+2", cur_core_enable, 1);
      end
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 300; k++) begin
         if (exp_q.size() == 0 && !cur_busy) break;
         step();
      end
      if (k >= 300) check("wait_done_timeout", 64'd0, 64'd1);
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int en0, n;
      rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      m_ready = 1'b1; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_ready", a_s_ready, 0);
      check("rst_busy", a_busy, 0);
      check("rst_m_valid", a_m_valid, 0);
      check("rst_m_data", a_m_data, 0);
      check("rst_err", a_err, 0);
      check("rst_core_rst", a_core_rst, 0);
      check("rst_core_en", a_core_enable, 0);
      check("rst_img0", a_img[0 +: DW], 0);
      rst = 1'b0;
      step();

      // Normal job
      core_dly = 20; core_val = 32'h0000_1234;
      exp_q.push_back(32'h0000_1234);
      send_frame(64, 0, 1);
      wait_done();
      check("normal_err", cur_err, 3'b000);
      check("normal_img0", cur_img[0 +: DW], 1);
      check("normal_img63", cur_img[63*DW +: DW], 64);

      // Backpressure
      m_ready = 1'b0; core_val = 32'h0000_5678;
      exp_q.push_back(32'h0000_5678);
      send_frame(64, 100, 0);
      n = 0;
      while (!cur_m_valid && n < 100) begin step(); n++; end
      check("bp_valid_seen", cur_m_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_m_valid", cur_m_valid, 1);
         check("bp_m_data", cur_m_data, 32'h0000_5678);
         check("bp_s_ready", cur_s_ready, 0);
         step();
      end
      m_ready = 1'b1;
      step();
      check("bp_idle_s_ready", cur_s_ready, 1);
      check("bp_m_valid_low", cur_m_valid, 0);
      check("bp_busy_low", cur_busy, 0);

      // Short frame then a good frame
      en0 = en_cnt;
      send_frame(10, 200, 0);
      check("short_err", cur_err, 3'b001);
      check("short_busy", cur_busy, 0);
      repeat (3) step();
      check("short_no_enable", en_cnt, en0);
      pulse_err_clr();
      check("short_err_clr", cur_err, 3'b000);
      core_val = 32'h0000_0042;
      exp_q.push_back(32'h0000_0042);
      send_frame(64, 300, 1);
      wait_done();
      check("after_short_err", cur_err, 3'b000);

      // Long frame
      core_val = 32'h0000_0BAD;
      exp_q.push_back(32'h0000_0BAD);
      send_frame(70, 1000, 1);
      wait_done();
      check("long_err", cur_err, 3'b010);
      check("long_img0", cur_img[0 +: DW], 1001);
      check("long_img63", cur_img[63*DW +: DW], 1064);
      pulse_err_clr();

      // Timeout on the 16-cycle instance
      sel = 1'b1; core_dly = 0;
      step();
      send_frame(64, 2000, 1);
      n = 0;
      while (cur_busy && n < 100) begin step(); n++; end
      check("tmo_cycles", n, 17);
      check("tmo_err", cur_err, 3'b100);
      check("tmo_m_valid", cur_m_valid, 0);
      check("tmo_busy", cur_busy, 0);
      pulse_err_clr();
      check("tmo_err_clr", cur_err, 3'b000);

      // Done on the final count wins over timeout
      core_dly = 16; core_val = 32'h0000_CAFE;
      exp_q.push_back(32'h0000_CAFE);
      send_frame(64, 3000, 1);
      wait_done();
      check("edge_err", cur_err, 3'b000);

      // Reset during WAIT
      sel = 1'b0; core_dly = 20; core_val = 32'h0000_7777;
      step();
      send_frame(64, 500, 1);
      repeat (5) step();
      check("pre_rst_busy", cur_busy, 1);
      rst = 1'b1;
      step();
      check("midrst_s_ready", cur_s_ready, 0);
      check("midrst_busy", cur_busy, 0);
      check("midrst_m_valid", cur_m_valid, 0);
      check("midrst_err", cur_err, 0);
      check("midrst_img0", cur_img[0 +: DW], 0);
      rst = 1'b0;
      repeat (25) step();
      check("late_done_ignored", cur_busy, 0);
      core_val = 32'h0000_4242;
      exp_q.push_back(32'h0000_4242);
      send_frame(64, 600, 1);
      wait_done();
      check("post_rst_err", cur_err, 3'b000);
      check("post_rst_img63", cur_img[63*DW +: DW], 664);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
